// File: rtl/sram_line_rmw_ctrl_pkg.sv
// Shared types and the byte-lane merge used by the line RMW controller.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package sram_line_rmw_pkg;

    // Controller sequence: idle, SRAM read issued, read data returned, line write.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        DATA = 2'd2,
        WR   = 2'd3
    } state_t;

    // Upper bound on line width the merge helper handles; callers zero-extend.
    localparam int MAX_BE_BITS   = 64;
    localparam int MAX_DATA_BITS = MAX_BE_BITS * 8;

    // Per-lane select: lanes enabled in be take new data, the rest keep old.
    // Only the low be_bits lanes are considered, so narrower lines can share it.
    function automatic logic [MAX_DATA_BITS-1:0] merge_bytes(
        input logic [MAX_DATA_BITS-1:0] data,
        input logic [MAX_DATA_BITS-1:0] old,
        input logic [MAX_BE_BITS-1:0]   be,
        input int                       be_bits
    );
        logic [MAX_DATA_BITS-1:0] result;
        result = old;
        for (int k = 0; k < MAX_BE_BITS; k++) begin
            if ((k < be_bits) && be[k]) begin
                result[8*k +: 8] = data[8*k +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_line_rmw_ctrl_if.sv
// Request/response bus between a requester and the line RMW controller.
// Latency: n/a (wiring only).
// Backpressure: requests use valid/ready; responses are single-cycle pulses with no backpressure.
interface sram_line_rmw_ctrl_if #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
);
    localparam int BE_BITS = DATA_BITS / 8;

    logic                 i_req_valid;
    logic                 o_req_ready;
    logic                 i_req_write;
    logic [ADDR_BITS-1:0] i_req_addr;
    logic [DATA_BITS-1:0] i_req_wdata;
    logic [BE_BITS-1:0]   i_req_be;
    logic                 o_rsp_valid;
    logic [DATA_BITS-1:0] o_rsp_rdata;

    // Requester side.
    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_be,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata
    );

    // Controller side.
    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_be,
        output o_req_ready, o_rsp_valid, o_rsp_rdata
    );

endinterface

// File: rtl/sram_line_rmw_ctrl.sv
// Turns word reads / byte-enabled writes into SRAM line accesses, using read-modify-write for partial writes.
// Latency: read rsp at T+2; full or zero-BE write ack at T+1; partial write ack at T+3 (T = accept cycle).
// Backpressure: ready only in IDLE, one request outstanding; responses cannot be stalled.
module sram_line_rmw_ctrl
    import sram_line_rmw_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 10,
    parameter int MEM_DATA_BITS = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    sram_line_rmw_ctrl_if.slave      bus,
    output logic [MEM_ADDR_BITS-1:0] o_sram_addr,
    output logic                     o_sram_write_en,
    output logic [MEM_DATA_BITS-1:0] o_sram_write_data,
    input  logic [MEM_DATA_BITS-1:0] i_sram_read_data
);

    localparam int BE_BITS = MEM_DATA_BITS / 8;

    state_t                   state_q;
    state_t                   state_d;
    logic [MEM_ADDR_BITS-1:0] addr_q;
    logic                     write_q;
    logic [MEM_DATA_BITS-1:0] wdata_q;
    logic [MEM_DATA_BITS-1:0] merged_q;
    logic [BE_BITS-1:0]       be_q;
    logic                     accept;
    logic                     be_full_q;
    logic                     be_zero_q;
    logic                     req_be_full;
    logic                     req_be_zero;

    assign accept      = bus.i_req_valid && bus.o_req_ready;
    assign be_full_q   = &be_q;
    assign be_zero_q   = ~|be_q;
    assign req_be_full = &bus.i_req_be;
    assign req_be_zero = ~|bus.i_req_be;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request on accept and latch the merged line after the SRAM read returns.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            merged_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.i_req_addr;
                write_q <= bus.i_req_write;
                wdata_q <= bus.i_req_wdata;
                be_q    <= bus.i_req_be;
            end
            if ((state_q == DATA) && write_q) begin
                merged_q <= MEM_DATA_BITS'(merge_bytes(MAX_DATA_BITS'(wdata_q),
                                                       MAX_DATA_BITS'(i_sram_read_data),
                                                       MAX_BE_BITS'(be_q),
                                                       BE_BITS));
            end
        end
    end

    // Next state and all outputs; write strobe and response are masked while reset is held.
    always_comb begin
        state_d           = state_q;
        bus.o_req_ready   = (state_q == IDLE) && !i_rst;
        bus.o_rsp_valid   = 1'b0;
        bus.o_rsp_rdata   = '0;
        o_sram_addr       = addr_q;
        o_sram_write_en   = 1'b0;
        o_sram_write_data = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Whole-line and empty writes need no old data; everything else reads first.
                    if (bus.i_req_write && (req_be_full || req_be_zero)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = DATA;
            end
            DATA: begin
                if (write_q) begin
                    state_d = WR;
                end else begin
                    state_d         = IDLE;
                    bus.o_rsp_valid = !i_rst;
                    bus.o_rsp_rdata = i_rst ? '0 : i_sram_read_data;
                end
            end
            WR: begin
                state_d           = IDLE;
                o_sram_write_en   = !i_rst && !be_zero_q;
                o_sram_write_data = be_full_q ? wdata_q : merged_q;
                bus.o_rsp_valid   = !i_rst;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_line_rmw_ctrl.sv
// Self-checking bench for sram_line_rmw_ctrl with a behavioural registered-read SRAM.
// Latency: n/a.
// Backpressure: driver holds valid until ready; responses checked against a scoreboard.
module tb_sram_line_rmw_ctrl;
    import sram_line_rmw_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rsp_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_line_rmw_ctrl_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

    logic [AW-1:0] sram_addr;
    logic          sram_we;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    sram_line_rmw_ctrl #(
        .MEM_ADDR_BITS(AW),
        .MEM_DATA_BITS(DW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .bus              (bus.slave),
        .o_sram_addr      (sram_addr),
        .o_sram_write_en  (sram_we),
        .o_sram_write_data(sram_wdata),
        .i_sram_read_data (sram_rdata)
    );

    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] ref_mem [1024];

    // Registered-read SRAM port with whole-line write.
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        sram_rdata <= mem[sram_addr];
    end

    int       n_checks = 0;
    int       n_errors = 0;
    int       cyc = 0;
    int       outstanding = 0;
    rsp_exp_t rsp_q[$];
    wr_exp_t  wr_q[$];
    rsp_exp_t mon_r;
    wr_exp_t  mon_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: every SRAM write and every response must match the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_ready", 64'(bus.o_req_ready), 64'(0));
            check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
            check("rst_write_en", 64'(sram_we), 64'(0));
        end else begin
            check("ready_while_busy", 64'(bus.o_req_ready && (outstanding > 0)), 64'(0));
            if (sram_we) begin
                check("write_expected", 64'(wr_q.size() != 0), 64'(1));
                if (wr_q.size() != 0) begin
                    mon_w = wr_q.pop_front();
                    check("write_addr", 64'(sram_addr), 64'(mon_w.addr));
                    check("write_data", 64'(sram_wdata), 64'(mon_w.data));
                    check("write_cycle", 64'(cyc), 64'(mon_w.cyc));
                end
            end
            if (bus.o_rsp_valid) begin
                check("rsp_expected", 64'(rsp_q.size() != 0), 64'(1));
                if (rsp_q.size() != 0) begin
                    mon_r = rsp_q.pop_front();
                    check("rsp_rdata", 64'(bus.o_rsp_rdata), 64'(mon_r.data));
                    check("rsp_cycle", 64'(cyc), 64'(mon_r.cyc));
                end
                outstanding--;
            end
        end
    end

    task automatic set_line(input int a, input logic [DW-1:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    // Drive one request, wait for accept, and queue what the DUT must produce.
    task automatic send(input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
        bit            acc;
        int            t;
        logic [DW-1:0] old;
        logic [DW-1:0] nw;
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b1;
        bus.i_req_write = wr;
        bus.i_req_addr  = a;
        bus.i_req_wdata = d;
        bus.i_req_be    = be;
        acc = 1'b0;
        t   = 0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (bus.o_req_ready) begin
                acc = 1'b1;
                t   = cyc;
            end
        end
        check("accept_timeout", 64'(acc), 64'(1));
        @(posedge clk);
        if (acc) begin
            old = ref_mem[a];
            if (!wr) begin
                rsp_q.push_back('{data: old, cyc: t + 2});
            end else if (be == '1) begin
                wr_q.push_back('{addr: a, data: d, cyc: t + 1});
                rsp_q.push_back('{data: '0, cyc: t + 1});
                ref_mem[a] = d;
            end else if (be == '0) begin
                rsp_q.push_back('{data: '0, cyc: t + 1});
            end else begin
                nw = DW'(merge_bytes(MAX_DATA_BITS'(d), MAX_DATA_BITS'(old), MAX_BE_BITS'(be), BW));
                wr_q.push_back('{addr: a, data: nw, cyc: t + 3});
                rsp_q.push_back('{data: '0, cyc: t + 3});
                ref_mem[a] = nw;
            end
            outstanding++;
        end
        #1;
        bus.i_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && outstanding != 0; i++) @(negedge clk);
        check("drain_outstanding", 64'(outstanding), 64'(0));
    endtask

    initial begin
        logic [1:0]    op;
        logic [BW-1:0] be;

        bus.i_req_valid = 1'b0;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_wdata = '0;
        bus.i_req_be    = '0;
        for (int i = 0; i < 1024; i++) set_line(i, (32'(i) * 32'h0101_0101) ^ 32'h5A5A_A5A5);
        set_line('h005, 32'hDEAD_BEEF);
        set_line('h020, 32'hAABB_CCDD);
        set_line('h030, 32'hCAFE_F00D);
        set_line('h040, 32'h5566_7788);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(bus.o_req_ready), 64'(1));
        check("reset_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
        check("reset_rsp_rdata", 64'(bus.o_rsp_rdata), 64'(0));
        check("reset_sram_addr", 64'(sram_addr), 64'(0));
        check("reset_sram_wdata", 64'(sram_wdata), 64'(0));
        check("reset_write_en", 64'(sram_we), 64'(0));

        // Directed: read, full write, partial write, zero-BE write.
        send(1'b0, 10'h005, 32'h0, 4'h0);
        drain();
        send(1'b1, 10'h010, 32'h1234_5678, 4'hF);
        drain();
        check("full_write_line", 64'(mem['h010]), 64'h1234_5678);
        send(1'b1, 10'h020, 32'h1122_3344, 4'b0101);
        drain();
        check("partial_write_line", 64'(mem['h020]), 64'hAA22_CC44);
        send(1'b0, 10'h020, 32'h0, 4'h0);
        drain();
        send(1'b1, 10'h030, 32'hFFFF_FFFF, 4'h0);
        drain();
        check("zero_be_line", 64'(mem['h030]), 64'hCAFE_F00D);

        // Reset while a partial write sits in DATA: nothing written, nothing acked.
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b1;
        bus.i_req_addr  = 10'h040;
        bus.i_req_wdata = 32'h9999_9999;
        bus.i_req_be    = 4'b0011;
        begin
            bit acc;
            acc = 1'b0;
            for (int i = 0; i < 20 && !acc; i++) begin
                @(negedge clk);
                acc = bus.o_req_ready;
            end
            check("abort_accept", 64'(acc), 64'(1));
        end
        @(posedge clk);
        #1 bus.i_req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_in_reset_ready", 64'(bus.o_req_ready), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(bus.o_req_ready), 64'(1));
        check("abort_line_intact", 64'(mem['h040]), 64'h5566_7788);
        send(1'b0, 10'h040, 32'h0, 4'h0);
        drain();

        // Random mixed traffic over a small address window to force line reuse.
        for (int n = 0; n < 1000; n++) begin
            op = 2'($urandom_range(0, 3));
            be = BW'($urandom_range(1, 14));
            case (op)
                2'd0: send(1'b0, AW'($urandom_range(0, 15)), $urandom, BW'($urandom));
                2'd1: send(1'b1, AW'($urandom_range(0, 15)), $urandom, '1);
                2'd2: send(1'b1, AW'($urandom_range(0, 15)), $urandom, be);
                default: send(1'b1, AW'($urandom_range(0, 15)), $urandom, '0);
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        check("rsp_queue_empty", 64'(rsp_q.size()), 64'(0));
        check("write_queue_empty", 64'(wr_q.size()), 64'(0));
        for (int i = 0; i < 16; i++) check("final_line", 64'(mem[i]), 64'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
